dft_scheduler: RTL

DFT_SCHEDULER -- requirements
Module: dft_scheduler

---
 rtl/fft_pkg.sv | 15 +
 rtl/wb_delay_line.sv | 50 +++++
 rtl/dft_scheduler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and defaults for the DFT sequencing logic.
package fft_pkg;

    localparam int ADDR_W_DEF = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/wb_delay_line.sv
// Valid+address shift register that aligns result writes with the accumulator latency.
module wb_delay_line #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr
);

    logic              valid_q [DEPTH];
    logic              valid_d [DEPTH];
    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [ADDR_W-1:0] addr_d  [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                // Address is zeroed when not valid so res_addr idles at 0.
                assign valid_d[gi] = in_valid;
                assign addr_d[gi]  = in_valid ? in_addr : '0;
            end else begin : g_tail
                assign valid_d[gi] = valid_q[gi-1];
                assign addr_d[gi]  = addr_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= valid_d[i];
                addr_q[i]  <= addr_d[i];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];

endmodule

// File: rtl/dft_scheduler.sv
// Sequencer for a direct DFT: RAM load into cache, N*N MAC sweep, delayed result writes.
module dft_scheduler
    import fft_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mac_en,
    input  logic [ADDR_W-1:0] samp_num,
    input  logic              data_loaded,
    output logic              load_nCompute,
    output logic [ADDR_W-1:0] n_index,
    output logic [ADDR_W-1:0] k_index,
    output logic              cache_we,
    output logic              acc_ce,
    output logic              acc_first,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] n_q, n_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [3:0]        drain_q, drain_d;
    logic              err_q, err_d;
    logic              last_n, last_k, abort;

    assign last_n = (n_q == len_q - ADDR_W'(1));
    assign last_k = (k_q == len_q - ADDR_W'(1));
    assign abort  = (state_q != S_IDLE) && !mac_en;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        len_d   = len_q;
        drain_d = drain_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (samp_num < ADDR_W'(2)) begin
                        err_d = 1'b1;
                    end else if (mac_en) begin
                        len_d   = samp_num;
                        n_d     = '0;
                        k_d     = '0;
                        state_d = S_WAIT_DATA;
                    end
                end
            end
            S_WAIT_DATA: begin
                if (data_loaded) begin
                    n_d     = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (last_n) begin
                    n_d     = '0;
                    k_d     = '0;
                    state_d = S_COMPUTE;
                end else begin
                    n_d = n_q + ADDR_W'(1);
                end
            end
            S_COMPUTE: begin
                if (last_n) begin
                    n_d = '0;
                    if (last_k) begin
                        k_d     = '0;
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        k_d = k_q + ADDR_W'(1);
                    end
                end else begin
                    n_d = n_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                // Hold off done until the last bin's write has left the delay line.
                if (drain_q == 4'(PIPE_LAT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            n_d     = '0;
            k_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            len_q   <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            len_q   <= len_d;
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end

    wb_delay_line #(
        .DEPTH  (PIPE_LAT),
        .ADDR_W (ADDR_W)
    ) u_wb_delay_line (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .in_valid  (acc_ce && last_n),
        .in_addr   (k_q),
        .out_valid (res_we),
        .out_addr  (res_addr)
    );

    assign load_nCompute = (state_q == S_IDLE) || (state_q == S_WAIT_DATA) || (state_q == S_LOAD);
    assign cache_we      = (state_q == S_LOAD);
    assign acc_ce        = (state_q == S_COMPUTE);
    assign acc_first     = acc_ce && (n_q == '0);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;
    assign n_index       = n_q;
    assign k_index       = k_q;

endmodule
